case_3_mul_arb: RTL

Round-robin arbiter and sequencer that shares one pipelined signed multiplier (15-bit × 8-bit → 15-bit by default) among N_REQ requesters. It sits between the case_3 compute lanes and a single multiplier instance. Each lane issues operand pairs over valid/ready. Results return in issue order on one tagged response port, protected by a credit-managed output FIFO.

---
 rtl/case_3_mul_arb_pkg.sv | 30 +++
 rtl/case_3_mul_pipe.sv | 78 +++++++
 rtl/case_3_mul_arb.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/case_3_mul_arb_pkg.sv
`default_nettype none
// ============================================================================
// case_3_mul_arb_pkg : default widths, id-width helper, response FIFO entry
// Rev 1.0
// ============================================================================
package case_3_mul_arb_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DIN0_W    = 15;
    localparam int DEF_DIN1_W    = 8;
    localparam int DEF_DOUT_W    = 15;
    localparam int DEF_NUM_STAGE = 2;

    // Entry fields are sized for the widest legal configuration (N_REQ <= 8).
    localparam int MAX_ID_W   = 3;
    localparam int MAX_DOUT_W = 32;

    function automatic int id_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    localparam int DEF_ID_W = id_w(DEF_N_REQ);

    typedef struct packed {
        logic [MAX_ID_W-1:0]   id;
        logic [MAX_DOUT_W-1:0] dout;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/case_3_mul_pipe.sv
`default_nettype none
// ============================================================================
// case_3_mul_pipe : NUM_STAGE-deep signed multiplier with valid/id tag shift.
// Macro CASE_3_MUL_ARB_SAT_EN selects saturating narrowing. Rev 1.0
// ============================================================================
module case_3_mul_pipe #(
    parameter int DIN0_W    = 15,
    parameter int DIN1_W    = 8,
    parameter int DOUT_W    = 15,
    parameter int NUM_STAGE = 2,
    parameter int ID_W      = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vld_i,
    input  logic [ID_W-1:0]   id_i,
    input  logic [DIN0_W-1:0] din0_i,
    input  logic [DIN1_W-1:0] din1_i,
    output logic              vld_o,
    output logic [ID_W-1:0]   id_o,
    output logic [DOUT_W-1:0] dout_o
);

    localparam int PROD_W = DIN0_W + DIN1_W;

    logic signed [PROD_W-1:0] w_a;
    logic signed [PROD_W-1:0] w_b;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] prod_q [NUM_STAGE];
    logic [ID_W-1:0]          id_q   [NUM_STAGE];
    logic [NUM_STAGE-1:0]     vld_q;

    assign w_a    = PROD_W'($signed(din0_i));
    assign w_b    = PROD_W'($signed(din1_i));
    assign w_prod = w_a * w_b;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int k = 0; k < NUM_STAGE; k++) begin
                prod_q[k] <= '0;
                id_q[k]   <= '0;
            end
        end else begin
            vld_q[0] <= vld_i;
            if (vld_i) begin
                prod_q[0] <= w_prod;
                id_q[0]   <= id_i;
            end
            for (int k = 1; k < NUM_STAGE; k++) begin
                vld_q[k]  <= vld_q[k-1];
                prod_q[k] <= prod_q[k-1];
                id_q[k]   <= id_q[k-1];
            end
        end
    end

    assign vld_o = vld_q[NUM_STAGE-1];
    assign id_o  = id_q[NUM_STAGE-1];

`ifdef CASE_3_MUL_ARB_SAT_EN
    // In range only when every bit above the result sign matches it.
    logic [PROD_W-DOUT_W:0] w_hi;
    assign w_hi = prod_q[NUM_STAGE-1][PROD_W-1:DOUT_W-1];

    always_comb begin
        dout_o = prod_q[NUM_STAGE-1][DOUT_W-1:0];
        if (!((&w_hi) || !(|w_hi))) begin
            dout_o = prod_q[NUM_STAGE-1][PROD_W-1] ? {1'b1, {(DOUT_W-1){1'b0}}}
                                                   : {1'b0, {(DOUT_W-1){1'b1}}};
        end
    end
`else
    assign dout_o = prod_q[NUM_STAGE-1][DOUT_W-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/case_3_mul_arb.sv
`default_nettype none
// ============================================================================
// case_3_mul_arb : round-robin sharing of one pipelined multiplier, in-order
// tagged responses through a credit-guarded FIFO. Macro: CASE_3_MUL_ARB_SAT_EN
// Rev 1.0
// ============================================================================
module case_3_mul_arb
    import case_3_mul_arb_pkg::*;
#(
    parameter  int N_REQ     = DEF_N_REQ,
    parameter  int DIN0_W    = DEF_DIN0_W,
    parameter  int DIN1_W    = DEF_DIN1_W,
    parameter  int DOUT_W    = DEF_DOUT_W,
    parameter  int NUM_STAGE = DEF_NUM_STAGE,
    parameter  int OUT_DEPTH = NUM_STAGE + 2,
    localparam int ID_W      = id_w(N_REQ)
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*DIN0_W-1:0]  req_din0,
    input  logic [N_REQ*DIN1_W-1:0]  req_din1,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DOUT_W-1:0]        rsp_dout
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]      w_gnt_idx;
    logic                 w_gnt_found;
    logic                 w_issue;
    logic                 w_pop;
    logic [DIN0_W-1:0]    w_din0;
    logic [DIN1_W-1:0]    w_din1;
    logic                 w_pipe_vld;
    logic [ID_W-1:0]      w_pipe_id;
    logic [DOUT_W-1:0]    w_pipe_dout;
    rsp_t                 w_wr_ent;
    logic                 w_placed;
    rsp_t                 fifo_q [OUT_DEPTH];
    rsp_t                 fifo_d [OUT_DEPTH];
    logic [OUT_DEPTH-1:0] fvld_q, fvld_d;

    // First valid lane at or after ptr_q, wrapping.
    always_comb begin
        int j;
        j           = 0;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!w_gnt_found && req_valid[ID_W'(j)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = ID_W'(j);
            end
        end
    end

    assign w_issue = w_gnt_found && (cnt_q < CNT_W'(OUT_DEPTH)) && !ap_rst;
    assign w_pop   = fvld_q[0] && rsp_ready;
    assign w_din0  = req_din0[int'(w_gnt_idx)*DIN0_W +: DIN0_W];
    assign w_din1  = req_din1[int'(w_gnt_idx)*DIN1_W +: DIN1_W];

    always_comb begin
        req_ready = '0;
        if (w_issue) req_ready[w_gnt_idx] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (w_issue) begin
            ptr_d = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (w_issue && !w_pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!w_issue && w_pop) cnt_d = cnt_q - CNT_W'(1);
    end

    case_3_mul_pipe #(
        .DIN0_W    (DIN0_W),
        .DIN1_W    (DIN1_W),
        .DOUT_W    (DOUT_W),
        .NUM_STAGE (NUM_STAGE),
        .ID_W      (ID_W)
    ) u_pipe (
        .clk_i  (ap_clk),
        .rst_i  (ap_rst),
        .vld_i  (w_issue),
        .id_i   (w_gnt_idx),
        .din0_i (w_din0),
        .din1_i (w_din1),
        .vld_o  (w_pipe_vld),
        .id_o   (w_pipe_id),
        .dout_o (w_pipe_dout)
    );

    // Shift FIFO: slot 0 is the head register driving rsp_*; empty slots stay zero.
    always_comb begin
        fifo_d   = fifo_q;
        fvld_d   = fvld_q;
        w_placed = 1'b0;
        w_wr_ent = '0;
        w_wr_ent.id[ID_W-1:0]     = w_pipe_id;
        w_wr_ent.dout[DOUT_W-1:0] = w_pipe_dout;
        if (w_pop) begin
            for (int i = 0; i < OUT_DEPTH - 1; i++) begin
                fifo_d[i] = fifo_q[i+1];
                fvld_d[i] = fvld_q[i+1];
            end
            fifo_d[OUT_DEPTH-1] = '0;
            fvld_d[OUT_DEPTH-1] = 1'b0;
        end
        if (w_pipe_vld) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                if (!w_placed && !fvld_d[i]) begin
                    fifo_d[i] = w_wr_ent;
                    fvld_d[i] = 1'b1;
                    w_placed  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            fvld_q <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            fvld_q <= fvld_d;
            for (int i = 0; i < OUT_DEPTH; i++) fifo_q[i] <= fifo_d[i];
        end
    end

    a_no_overflow: assert property (@(posedge ap_clk) disable iff (ap_rst)
                                    (!w_pipe_vld || w_placed));

    assign rsp_valid = fvld_q[0];
    assign rsp_id    = fifo_q[0].id[ID_W-1:0];
    assign rsp_dout  = fifo_q[0].dout[DOUT_W-1:0];

endmodule
`default_nettype wire
